micro_sequencer: RTL and testbench
==================================

# micro_sequencer

Next-state sequencer for the microprogrammed CPU controller. Each cycle it takes the controller's branch type (`ty`), its direct and conditional target addresses (`db_addr`, `bc_addr`) and the executing instruction register (`ire`), and registers the 5-bit microstate the controller executes next. It also performs the two instruction dispatches: IB selects the instruction start state, SB selects the memory-operation state after address formation. It counts dispatched instructions and flags illegal encodings.

## Interface
Parameters:
- `CNT_W`, 16, width of the dispatched-instruction counter.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  memory wait; 1 holds every register.
- `ty`  in  2  branch type from controller: IB=00, SB=01, BC=10, DB=11.
- `db_addr`  in  5  direct-branch target.
- `bc_addr`  in  5  conditional-branch target, already resolved by the controller from `flag_z`.
- `ire`  in  16  executing instruction register.
- `state`  out  5  current microstate.
- `dispatch`  out  1  one-cycle pulse; IB dispatch taken this cycle.
- `illegal_op`  out  1  one-cycle pulse; IB/SB decode found an illegal encoding.
- `illegal_seen`  out  1  sticky OR of `illegal_op`.
- `instr_count`  out  `CNT_W`  number of IB dispatches, wraps.

## Operation
- Instruction fields: opcode `ire[15:12]`; ALU function `ire[11:9]` is not decoded here; mode `ire[8]` (0 = register, 1 = memory); address mode `ire[7]` (0 = absolute, 1 = register indirect).
- Opcodes: LDR=0, STR=1, TST=2, OPR=3, BRZ=4, POP=5, PUSH=6. Codes 7–15 are illegal.
- IB dispatch:
  - BRZ → brzz1 (00101). POP → popr1 (10000). PUSH → push1 (10010). Mode is ignored for these three.
  - Mode 0: LDR → ldrr1 (01110), STR → strr1 (01111), OPR → oprr1 (10100). TST is illegal.
  - Mode 1 with LDR/STR/TST/OPR: `ire[7]`=0 → abdm1 (00000), `ire[7]`=1 → adrm1 (00100).
- SB dispatch: LDR → ldrm1 (01000), STR → strm1 (01010), TST → test1 (01011), OPR → oprm1 (01100). Any other opcode is illegal.
- BC: next state = `bc_addr`. DB: next state = `db_addr`. No range check on either.
- Illegal decode, from IB or SB:
  - next state = brzz3 (00111), which refetches the next instruction.
  - `illegal_op` pulses and `illegal_seen` sets.
  - `dispatch` and `instr_count` do not change.
- Legal IB dispatch: `dispatch` pulses and `instr_count` increments modulo 2^CNT_W.

## Timing
- Reset values: `state`=brzz3 (00111), so the first action after reset is an instruction fetch. `dispatch`=0, `illegal_op`=0, `illegal_seen`=0, `instr_count`=0.
- Next-state logic is combinational on `ty`, `db_addr`, `bc_addr`, `ire` and `state`. All outputs are registered. Latency from input to `state` is 1 cycle.
- `stall`=1 holds `state`, `illegal_seen` and `instr_count`, and forces `dispatch`=0 and `illegal_op`=0 for that cycle. When `stall` deasserts, inputs are re-evaluated; nothing is queued.
- `reset` takes priority over `stall`. Reset in any state returns to brzz3 on the next edge, with counters cleared.
- `instr_count` at all ones plus a legal IB dispatch → 0, with no flag.
- `ire` is sampled only in cycles where `ty` is IB or SB. It must be stable in those cycles; the controller loads `ire` in the preceding state.

## Structure
- Shared package `cpu_pkg` holds:
  - all 22 microstate encodings (abdm1…oprr2);
  - TY codes IB/SB/BC/DB;
  - opcode constants;
  - the field bit positions.
- The controller uses the same package.
- One combinational sub-module, `ir_dispatch`:
  - inputs: `ire`, `ty`;
  - outputs: dispatch target and illegal flag, for both IB and SB.
- The top level holds the state register, stall/reset muxing and the counters.

## Test plan
- Reset asserted for 2 cycles, then released with `ty`=DB, `db_addr`=00110 → `state`=00111 while reset is held, then 00110; `instr_count`=0.
- `ty`=IB, `ire`=16'h0180 (LDR, memory, indirect) → `state`=00100, `dispatch`=1, `instr_count` 0→1. Next cycle `ty`=SB, same `ire` → `state`=01000.
- `ty`=IB, `ire`=16'h2000 (TST, register mode) → `state`=00111, `illegal_op`=1 for one cycle, `illegal_seen`=1, `instr_count` unchanged.
- `ty`=BC, `bc_addr`=00110, with `stall`=1 for 3 cycles → `state` held for those 3 cycles, then 00110 on the first unstalled edge.
- `instr_count` preloaded to 16'hFFFF by 65535 dispatches of `ire`=16'h4000 (BRZ) → next dispatch gives `state`=00101 and `instr_count`=0.
- `ty`=IB, `ire`=16'hF000 (opcode 15), with `reset` asserted in the same cycle → `state`=00111, `illegal_op`=0, `illegal_seen`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the microprogrammed CPU controller and its sequencer:
// microstate encodings, branch types, opcodes and instruction field positions.
package cpu_pkg;

  typedef enum logic [4:0] {
    ABDM1 = 5'b00000,
    ABDM2 = 5'b00001,
    ABDM3 = 5'b00010,
    ABDM4 = 5'b00011,
    ADRM1 = 5'b00100,
    BRZZ1 = 5'b00101,
    BRZZ2 = 5'b00110,
    BRZZ3 = 5'b00111,
    LDRM1 = 5'b01000,
    LDRM2 = 5'b01001,
    STRM1 = 5'b01010,
    TEST1 = 5'b01011,
    OPRM1 = 5'b01100,
    OPRM2 = 5'b01101,
    LDRR1 = 5'b01110,
    STRR1 = 5'b01111,
    POPR1 = 5'b10000,
    POPR2 = 5'b10001,
    PUSH1 = 5'b10010,
    PUSH2 = 5'b10011,
    OPRR1 = 5'b10100,
    OPRR2 = 5'b10101
  } micro_state_t;

  typedef enum logic [1:0] {
    TY_IB = 2'b00,
    TY_SB = 2'b01,
    TY_BC = 2'b10,
    TY_DB = 2'b11
  } ty_t;

  localparam logic [3:0] OP_LDR  = 4'd0;
  localparam logic [3:0] OP_STR  = 4'd1;
  localparam logic [3:0] OP_TST  = 4'd2;
  localparam logic [3:0] OP_OPR  = 4'd3;
  localparam logic [3:0] OP_BRZ  = 4'd4;
  localparam logic [3:0] OP_POP  = 4'd5;
  localparam logic [3:0] OP_PUSH = 4'd6;

  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 12;
  localparam int unsigned MODE_BIT  = 8;
  localparam int unsigned AMODE_BIT = 7;

endpackage

// File: rtl/ir_dispatch.sv
// Instruction dispatch decode: maps the instruction register to the IB
// start state or the SB memory-operation state, flagging illegal encodings.
import cpu_pkg::*;

module ir_dispatch (
  input  logic [15:0] ire,
  input  logic [1:0]  ty,
  output logic [4:0]  target,
  output logic        illegal
);

  logic [3:0] opcode;
  logic       unused_fields;

  assign opcode        = ire[OPC_MSB:OPC_LSB];
  assign unused_fields = ^{ire[11:9], ire[6:0]};

  // Decode opcode/mode into a dispatch target; illegal codes refetch via BRZZ3.
  always_comb begin
    target  = BRZZ3;
    illegal = 1'b0;
    case (ty)
      TY_IB: begin
        case (opcode)
          OP_BRZ:  target = BRZZ1;
          OP_POP:  target = POPR1;
          OP_PUSH: target = PUSH1;
          OP_LDR, OP_STR, OP_TST, OP_OPR: begin
            if (ire[MODE_BIT]) begin
              target = ire[AMODE_BIT] ? ADRM1 : ABDM1;
            end else begin
              case (opcode)
                OP_LDR:  target = LDRR1;
                OP_STR:  target = STRR1;
                OP_OPR:  target = OPRR1;
                default: illegal = 1'b1;
              endcase
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      TY_SB: begin
        case (opcode)
          OP_LDR:  target = LDRM1;
          OP_STR:  target = STRM1;
          OP_TST:  target = TEST1;
          OP_OPR:  target = OPRM1;
          default: illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Next-microstate sequencer: registers the next state from the branch type,
// performs IB/SB dispatch, counts dispatched instructions, flags illegal ops.
import cpu_pkg::*;

module micro_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       ty,
  input  logic [4:0]       db_addr,
  input  logic [4:0]       bc_addr,
  input  logic [15:0]      ire,
  output logic [4:0]       state,
  output logic             dispatch,
  output logic             illegal_op,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] instr_count
);

  logic [4:0] dec_target;
  logic       dec_illegal;
  logic [4:0] state_next;
  logic       dispatch_next;
  logic       illegal_next;

  ir_dispatch u_ir_dispatch (
    .ire     (ire),
    .ty      (ty),
    .target  (dec_target),
    .illegal (dec_illegal)
  );

  // State and counter registers; reset beats stall, stall freezes and drops pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= BRZZ3;
      dispatch     <= 1'b0;
      illegal_op   <= 1'b0;
      illegal_seen <= 1'b0;
      instr_count  <= '0;
    end else if (stall) begin
      dispatch   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state      <= state_next;
      dispatch   <= dispatch_next;
      illegal_op <= illegal_next;
      if (illegal_next)  illegal_seen <= 1'b1;
      if (dispatch_next) instr_count  <= instr_count + CNT_W'(1);
    end
  end

  // Next microstate selection by branch type.
  always_comb begin
    state_next = state;
    case (ty)
      TY_IB, TY_SB: state_next = dec_target;
      TY_BC:        state_next = bc_addr;
      TY_DB:        state_next = db_addr;
      default:      state_next = state;
    endcase
  end

  // Pulse outputs for the coming edge: legal IB dispatch or illegal decode.
  always_comb begin
    dispatch_next = (ty == TY_IB) && !dec_illegal;
    illegal_next  = dec_illegal;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed steps followed by random
// stimulus, checked against a behavioural model of the sequencing rules.
module tb_micro_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  ty = 2'b11;
  logic [4:0]  db_addr = '0;
  logic [4:0]  bc_addr = '0;
  logic [15:0] ire = '0;
  logic [4:0]  state;
  logic        dispatch;
  logic        illegal_op;
  logic        illegal_seen;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;

  // Model of the observable outputs
  int e_state = 7;
  int e_disp  = 0;
  int e_ill   = 0;
  int e_seen  = 0;
  int e_cnt   = 0;

  micro_sequencer #(.CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .ty           (ty),
    .db_addr      (db_addr),
    .bc_addr      (bc_addr),
    .ire          (ire),
    .state        (state),
    .dispatch     (dispatch),
    .illegal_op   (illegal_op),
    .illegal_seen (illegal_seen),
    .instr_count  (instr_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Dispatch table written from the instruction-set rules: returns next state and legality.
  task automatic ref_decode(input bit is_ib, input logic [15:0] ir, output int nxt, output int ill);
    int op;
    int mode;
    int amode;
    int reg_tbl[4];
    int mem_tbl[4];
    op    = int'(ir[15:12]);
    mode  = int'(ir[8]);
    amode = int'(ir[7]);
    reg_tbl = '{14, 15, -1, 20};
    mem_tbl = '{8, 10, 11, 12};
    nxt = -1;
    if (is_ib) begin
      if (op == 4)      nxt = 5;
      else if (op == 5) nxt = 16;
      else if (op == 6) nxt = 18;
      else if (op < 4)  nxt = (mode == 1) ? (amode == 1 ? 4 : 0) : reg_tbl[op];
    end else if (op < 4) begin
      nxt = mem_tbl[op];
    end
    ill = (nxt < 0) ? 1 : 0;
    if (ill == 1) nxt = 7;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(e_state));
    chk({tag, ".dispatch"}, 32'(dispatch), 32'(e_disp));
    chk({tag, ".illegal_op"}, 32'(illegal_op), 32'(e_ill));
    chk({tag, ".illegal_seen"}, 32'(illegal_seen), 32'(e_seen));
    chk({tag, ".instr_count"}, 32'(instr_count), 32'(e_cnt));
  endtask

  // Apply one cycle of inputs, advance the model on the edge, then check 1 time unit later.
  task automatic step(input bit r, input bit s, input logic [1:0] t, input logic [4:0] db,
                      input logic [4:0] bc, input logic [15:0] ir, input bit do_chk,
                      input string tag);
    int nxt;
    int ill;
    reset = r; stall = s; ty = t; db_addr = db; bc_addr = bc; ire = ir;
    @(posedge clock);
    if (r) begin
      e_state = 7; e_disp = 0; e_ill = 0; e_seen = 0; e_cnt = 0;
    end else if (s) begin
      e_disp = 0; e_ill = 0;
    end else begin
      e_disp = 0; e_ill = 0;
      case (t)
        2'b10: e_state = int'(bc);
        2'b11: e_state = int'(db);
        default: begin
          ref_decode(t == 2'b00, ir, nxt, ill);
          e_state = nxt;
          if (ill == 1) begin
            e_ill = 1; e_seen = 1;
          end else if (t == 2'b00) begin
            e_disp = 1;
            e_cnt = (e_cnt + 1) % 65536;
          end
        end
      endcase
    end
    #1;
    if (do_chk) check_all(tag);
  endtask

  initial begin
    // Reset held two cycles with a DB request pending
    step(1, 0, 2'b11, 5'b00110, 5'd0, 16'h0000, 1, "rst0");
    chk("rst0_state_const", 32'(state), 32'h07);
    step(1, 0, 2'b11, 5'b00110, 5'd0, 16'h0000, 1, "rst1");
    step(0, 0, 2'b11, 5'b00110, 5'd0, 16'h0000, 1, "db_after_rst");
    chk("db_state_const", 32'(state), 32'h06);
    chk("db_count_const", 32'(instr_count), 32'h0);

    // LDR memory indirect: IB then SB
    step(0, 0, 2'b00, 5'd0, 5'd0, 16'h0180, 1, "ib_ldr");
    chk("ib_ldr_state_const", 32'(state), 32'h04);
    chk("ib_ldr_disp_const", 32'(dispatch), 32'h1);
    chk("ib_ldr_cnt_const", 32'(instr_count), 32'h1);
    step(0, 0, 2'b01, 5'd0, 5'd0, 16'h0180, 1, "sb_ldr");
    chk("sb_ldr_state_const", 32'(state), 32'h08);

    // TST in register mode is illegal
    step(0, 0, 2'b00, 5'd0, 5'd0, 16'h2000, 1, "ib_tst_reg");
    chk("tst_ill_const", 32'(illegal_op), 32'h1);
    chk("tst_cnt_const", 32'(instr_count), 32'h1);
    step(0, 0, 2'b11, 5'd5, 5'd0, 16'h2000, 1, "after_ill");
    chk("ill_pulse_drop", 32'(illegal_op), 32'h0);
    chk("ill_sticky", 32'(illegal_seen), 32'h1);

    // BC under stall for 3 cycles, then released
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b10, 5'd0, 5'b00110, 16'h0000, 1, "bc_stall");
      chk("bc_stall_hold_const", 32'(state), 32'h05);
    end
    step(0, 0, 2'b10, 5'd0, 5'b00110, 16'h0000, 1, "bc_release");
    chk("bc_release_const", 32'(state), 32'h06);

    // Counter wrap: preload to FFFF with BRZ dispatches, then one more
    step(1, 0, 2'b11, 5'd0, 5'd0, 16'h0000, 1, "wrap_rst");
    for (int i = 0; i < 65535; i++)
      step(0, 0, 2'b00, 5'd0, 5'd0, 16'h4000, 0, "preload");
    check_all("preloaded");
    chk("preload_cnt_const", 32'(instr_count), 32'hFFFF);
    step(0, 0, 2'b00, 5'd0, 5'd0, 16'h4000, 1, "wrap");
    chk("wrap_state_const", 32'(state), 32'h05);
    chk("wrap_cnt_const", 32'(instr_count), 32'h0);
    chk("wrap_no_flag", 32'(illegal_op), 32'h0);

    // Illegal opcode with reset in the same cycle: reset wins
    step(0, 0, 2'b01, 5'd0, 5'd0, 16'h7000, 1, "sb_ill");
    chk("sb_ill_seen_const", 32'(illegal_seen), 32'h1);
    step(1, 0, 2'b00, 5'd0, 5'd0, 16'hF000, 1, "rst_vs_ill");
    chk("rst_ill_state_const", 32'(state), 32'h07);
    chk("rst_ill_op_const", 32'(illegal_op), 32'h0);
    chk("rst_ill_seen_const", 32'(illegal_seen), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [15:0] r_ire;
      r_ire = 16'($urandom);
      if ($urandom_range(0, 3) != 0) r_ire[15:12] = 4'($urandom_range(0, 7));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, 2'($urandom),
           5'($urandom), 5'($urandom), r_ire, 1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
